// File: rtl/line_fetch_scheduler.sv
// Framebuffer-to-linebuffer fetch sequencer: issues burst reads per display line
// and fills one bank of a ping-pong linebuffer while the other bank is displayed.
module line_fetch_scheduler #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int WORDS_PER_LINE = 160,
    parameter int DISPLAY_HEIGHT = 480,
    parameter int MAX_BURST      = 16
) (
    input  logic                      pclk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [MEM_ADDR_WIDTH-1:0] frame_base,
    input  logic [MEM_ADDR_WIDTH-1:0] line_stride,
    input  logic                      req_frame,
    input  logic                      req_line,
    output logic                      rd_req,
    output logic [MEM_ADDR_WIDTH-1:0] rd_addr,
    output logic [7:0]                rd_len,
    input  logic                      rd_ack,
    input  logic [31:0]               rd_data,
    input  logic                      rd_valid,
    output logic                      lb_we,
    output logic [ADDRESS_WIDTH-1:0]  lb_waddr,
    output logic [31:0]               lb_wdata,
    output logic                      lb_bank,
    output logic                      rd_bank,
    output logic                      busy,
    output logic                      underrun,
    output logic [12:0]               line_idx
);
    localparam logic [31:0] WPL    = 32'(WORDS_PER_LINE);
    localparam logic [31:0] MAXB   = 32'(MAX_BURST);
    localparam logic [12:0] HEIGHT = 13'(DISPLAY_HEIGHT);

    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;
    state_t state_reg;

    // bit 0: req_frame, bit 1: req_line
    logic [1:0] req_cur_reg, req_prev_reg;
    logic       frame_evt, line_evt;

    logic                      frame_pend_reg, pending_reg;
    logic [MEM_ADDR_WIDTH-1:0] pend_base_reg, pend_stride_reg;
    logic [MEM_ADDR_WIDTH-1:0] line_addr_reg, stride_reg, burst_addr_reg;
    logic [31:0]               burst_word_reg;
    logic [7:0]                burst_cnt_reg;
    logic [ADDRESS_WIDTH-1:0]  word_idx_reg;

    logic                      rd_req_reg, lb_we_reg, lb_bank_reg, rd_bank_reg, underrun_reg;
    logic [MEM_ADDR_WIDTH-1:0] rd_addr_reg;
    logic [7:0]                rd_len_reg;
    logic [ADDRESS_WIDTH-1:0]  lb_waddr_reg;
    logic [31:0]               lb_wdata_reg;
    logic [12:0]               line_idx_reg;

    logic [31:0]               remaining;
    logic [7:0]                len_next;
    logic [MEM_ADDR_WIDTH-1:0] new_base, new_stride;

    assign frame_evt = req_cur_reg[0] & ~req_prev_reg[0];
    assign line_evt  = req_cur_reg[1] & ~req_prev_reg[1];

    always_comb begin
        remaining  = WPL - burst_word_reg;
        len_next   = (remaining > MAXB) ? MAXB[7:0] : remaining[7:0];
        // a deferred frame uses the base/stride captured when its edge arrived
        new_base   = frame_evt ? frame_base  : pend_base_reg;
        new_stride = frame_evt ? line_stride : pend_stride_reg;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_reg       <= IDLE;
            req_cur_reg     <= '0;
            req_prev_reg    <= '0;
            frame_pend_reg  <= 1'b0;
            pending_reg     <= 1'b0;
            pend_base_reg   <= '0;
            pend_stride_reg <= '0;
            line_addr_reg   <= '0;
            stride_reg      <= '0;
            burst_addr_reg  <= '0;
            burst_word_reg  <= '0;
            burst_cnt_reg   <= '0;
            word_idx_reg    <= '0;
            rd_req_reg      <= 1'b0;
            rd_addr_reg     <= '0;
            rd_len_reg      <= '0;
            lb_we_reg       <= 1'b0;
            lb_waddr_reg    <= '0;
            lb_wdata_reg    <= '0;
            lb_bank_reg     <= 1'b0;
            rd_bank_reg     <= 1'b1;
            underrun_reg    <= 1'b0;
            line_idx_reg    <= '0;
        end else begin
            req_cur_reg  <= {req_line, req_frame};
            req_prev_reg <= req_cur_reg;
            lb_we_reg    <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (frame_evt || frame_pend_reg) begin
                        frame_pend_reg <= 1'b0;
                        pending_reg    <= 1'b0;
                        line_idx_reg   <= '0;
                        line_addr_reg  <= new_base;
                        stride_reg     <= new_stride;
                        if (enable) begin
                            state_reg      <= REQ;
                            burst_addr_reg <= new_base;
                            burst_word_reg <= '0;
                            word_idx_reg   <= '0;
                        end
                    end else if (line_evt && pending_reg) begin
                        rd_bank_reg <= lb_bank_reg;
                        lb_bank_reg <= ~lb_bank_reg;
                        pending_reg <= 1'b0;
                        if (line_idx_reg < HEIGHT && enable) begin
                            state_reg      <= REQ;
                            burst_addr_reg <= line_addr_reg;
                            burst_word_reg <= '0;
                            word_idx_reg   <= '0;
                        end
                    end
                end
                REQ: begin
                    // first REQ cycle keeps rd_req low, giving the gap between bursts
                    if (!rd_req_reg) begin
                        rd_req_reg    <= 1'b1;
                        rd_addr_reg   <= burst_addr_reg;
                        rd_len_reg    <= len_next;
                        burst_cnt_reg <= '0;
                    end else if (rd_ack) begin
                        rd_req_reg <= 1'b0;
                        state_reg  <= DATA;
                    end
                end
                DATA: begin
                    if (rd_valid) begin
                        lb_we_reg     <= 1'b1;
                        lb_waddr_reg  <= word_idx_reg;
                        lb_wdata_reg  <= rd_data;
                        word_idx_reg  <= word_idx_reg + ADDRESS_WIDTH'(1);
                        burst_cnt_reg <= burst_cnt_reg + 8'd1;
                        if (burst_cnt_reg == rd_len_reg - 8'd1) begin
                            burst_addr_reg <= burst_addr_reg + (MEM_ADDR_WIDTH'(rd_len_reg) << 2);
                            burst_word_reg <= burst_word_reg + 32'(rd_len_reg);
                            state_reg      <= (burst_word_reg + 32'(rd_len_reg) < WPL) ? REQ : DONE;
                        end
                    end
                end
                DONE: begin
                    // a frame request seen during this fetch voids the line it produced
                    pending_reg   <= ~(frame_pend_reg | frame_evt);
                    line_idx_reg  <= line_idx_reg + 13'd1;
                    line_addr_reg <= line_addr_reg + stride_reg;
                    word_idx_reg  <= '0;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase

            if (state_reg != IDLE) begin
                if (frame_evt) begin
                    frame_pend_reg  <= 1'b1;
                    pend_base_reg   <= frame_base;
                    pend_stride_reg <= line_stride;
                end else if (line_evt) begin
                    if (pending_reg) begin
                        rd_bank_reg <= lb_bank_reg;
                        lb_bank_reg <= ~lb_bank_reg;
                        pending_reg <= 1'b0;
                    end else begin
                        underrun_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign rd_req   = rd_req_reg;
    assign rd_addr  = rd_addr_reg;
    assign rd_len   = rd_len_reg;
    assign lb_we    = lb_we_reg;
    assign lb_waddr = lb_waddr_reg;
    assign lb_wdata = lb_wdata_reg;
    assign lb_bank  = lb_bank_reg;
    assign rd_bank  = rd_bank_reg;
    assign busy     = (state_reg != IDLE);
    assign underrun = underrun_reg;
    assign line_idx = line_idx_reg;
endmodule

// File: tb/tb_line_fetch_scheduler.sv
// Bench for line_fetch_scheduler: table of per-line fetches plus hand-written
// underrun, deferred-frame and mid-burst-reset sequences; writes go through a scoreboard.
module tb_line_fetch_scheduler;
    localparam int WPL  = 20;
    localparam int MAXB = 8;
    localparam int H    = 3;

    logic        pclk = 1'b0;
    logic        reset, enable, req_frame, req_line, rd_ack, rd_valid;
    logic [31:0] frame_base, line_stride, rd_data;
    logic        rd_req, lb_we, lb_bank, rd_bank, busy, underrun;
    logic [31:0] rd_addr, lb_waddr, lb_wdata;
    logic [7:0]  rd_len;
    logic [12:0] line_idx;

    line_fetch_scheduler #(
        .ADDRESS_WIDTH(32), .MEM_ADDR_WIDTH(32), .WORDS_PER_LINE(WPL),
        .DISPLAY_HEIGHT(H), .MAX_BURST(MAXB)
    ) dut (
        .pclk(pclk), .reset(reset), .enable(enable),
        .frame_base(frame_base), .line_stride(line_stride),
        .req_frame(req_frame), .req_line(req_line),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .lb_we(lb_we), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
        .lb_bank(lb_bank), .rd_bank(rd_bank), .busy(busy),
        .underrun(underrun), .line_idx(line_idx)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] data;
        logic        bank;
    } wr_t;
    wr_t  exp_wr[$];
    wr_t  mon_e;
    logic exp_lb_bank;

    typedef struct {
        bit          is_frame;
        logic [31:0] base;
        int          ack_dly;
        int          gap;
        logic        exp_rd_bank;
        logic        exp_lb_bank;
        logic [12:0] exp_line_idx;
    } vec_t;
    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a, input int i);
        return a ^ (32'(i) * 32'h01010101) ^ 32'hA5A50000;
    endfunction

    // Scoreboard consumer: every linebuffer write must match the oldest expected word.
    always @(negedge pclk) begin
        if (lb_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lb_we_unexpected: got write waddr=%0d data=0x%0h, expected no write", lb_waddr, lb_wdata);
            end else begin
                mon_e = exp_wr.pop_front();
                $display("write waddr=%0d data=0x%0h bank=%0d", lb_waddr, lb_wdata, lb_bank);
                check("lb_waddr", lb_waddr, mon_e.waddr);
                check("lb_wdata", lb_wdata, mon_e.data);
                check("lb_bank_on_write", 32'(lb_bank), 32'(mon_e.bank));
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_rd_req", 32'(rd_req), 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rd_len", 32'(rd_len), 0);
        check("rst_lb_we", 32'(lb_we), 0);
        check("rst_lb_waddr", lb_waddr, 0);
        check("rst_lb_wdata", lb_wdata, 0);
        check("rst_lb_bank", 32'(lb_bank), 0);
        check("rst_rd_bank", 32'(rd_bank), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_line_idx", 32'(line_idx), 0);
    endtask

    task automatic pulse(input bit is_frame);
        if (is_frame) req_frame = 1'b1;
        else          req_line  = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        req_frame = 1'b0;
        req_line  = 1'b0;
    endtask

    task automatic wait_rd_req();
        for (int i = 0; i < 40; i++) begin
            if (rd_req === 1'b1) break;
            @(negedge pclk);
        end
        check("rd_req_seen", 32'(rd_req), 1);
    endtask

    // evt_kind: 0 none, 1 req_line, 2 req_frame, raised at data word evt_at
    task automatic serve_burst(input logic [31:0] ea, input int len, input int off,
                               input int ack_dly, input int gap, input int evt_at, input int evt_kind);
        logic [31:0] d;
        wait_rd_req();
        if (rd_req !== 1'b1) return;
        $display("burst addr=0x%0h len=%0d", rd_addr, rd_len);
        check("rd_addr", rd_addr, ea);
        check("rd_len", 32'(rd_len), 32'(len));
        for (int k = 0; k < ack_dly; k++) begin
            @(negedge pclk);
            check("rd_req_held", 32'(rd_req), 1);
            check("rd_addr_held", rd_addr, ea);
            check("rd_len_held", 32'(rd_len), 32'(len));
            check("no_lb_we_before_ack", 32'(lb_we), 0);
        end
        rd_ack = 1'b1;
        @(negedge pclk);
        rd_ack = 1'b0;
        check("rd_req_drop", 32'(rd_req), 0);
        for (int i = 0; i < len; i++) begin
            if (i == evt_at && evt_kind == 1) req_line  = 1'b1;
            if (i == evt_at && evt_kind == 2) req_frame = 1'b1;
            d = pat(ea, i);
            rd_valid = 1'b1;
            rd_data  = d;
            exp_wr.push_back('{waddr: 32'(off + i), data: d, bank: exp_lb_bank});
            @(negedge pclk);
            rd_valid = 1'b0;
            repeat (gap) @(negedge pclk);
        end
        if (evt_kind != 0) begin
            req_line  = 1'b0;
            req_frame = 1'b0;
        end
    endtask

    task automatic fetch_line(input logic [31:0] base, input int ack_dly, input int gap,
                              input int evt_at, input int evt_kind);
        int len;
        for (int off = 0; off < WPL; off += MAXB) begin
            len = (WPL - off > MAXB) ? MAXB : WPL - off;
            serve_burst(base + 32'(4 * off), len, off, ack_dly, gap,
                        (off == 0) ? evt_at : -1, (off == 0) ? evt_kind : 0);
        end
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b0) break;
            @(negedge pclk);
        end
        check("busy_low_after_done", 32'(busy), 0);
        check("scoreboard_drained", 32'(exp_wr.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h1000, 0, 0, 1'b1, 1'b0, 13'd1};
        vecs[1] = '{1'b0, 32'h1100, 5, 0, 1'b0, 1'b1, 13'd2};
        vecs[2] = '{1'b0, 32'h1200, 0, 2, 1'b1, 1'b0, 13'd3};

        reset = 1'b1; enable = 1'b1; req_frame = 1'b0; req_line = 1'b0;
        rd_ack = 1'b0; rd_valid = 1'b0; rd_data = '0;
        frame_base = 32'h1000; line_stride = 32'h100; exp_lb_bank = 1'b0;
        repeat (3) @(negedge pclk);
        check_reset_outputs();
        reset = 1'b0;
        @(negedge pclk);

        // One frame of H lines driven from the table
        for (int v = 0; v < 3; v++) begin
            pulse(vecs[v].is_frame);
            check("rd_bank_after_evt", 32'(rd_bank), 32'(vecs[v].exp_rd_bank));
            check("lb_bank_after_evt", 32'(lb_bank), 32'(vecs[v].exp_lb_bank));
            check("busy_after_evt", 32'(busy), 1);
            exp_lb_bank = vecs[v].exp_lb_bank;
            fetch_line(vecs[v].base, vecs[v].ack_dly, vecs[v].gap, -1, 0);
            check("line_idx", 32'(line_idx), 32'(vecs[v].exp_line_idx));
            check("underrun_clear", 32'(underrun), 0);
        end

        // Last line displayed: swap but no further fetch; then blanking edges are ignored
        pulse(1'b0);
        check("rd_bank_last_swap", 32'(rd_bank), 0);
        check("lb_bank_last_swap", 32'(lb_bank), 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge pclk);
            check("no_rd_req_blanking", 32'(rd_req), 0);
        end
        check("busy_blanking", 32'(busy), 0);
        pulse(1'b0);
        @(negedge pclk);
        check("rd_bank_blank_edge", 32'(rd_bank), 0);
        check("lb_bank_blank_edge", 32'(lb_bank), 1);
        check("underrun_blank_edge", 32'(underrun), 0);
        check("busy_blank_edge", 32'(busy), 0);

        // Underrun: req_line arrives while line 1 is still receiving gapped data
        pulse(1'b1);
        exp_lb_bank = 1'b1;
        fetch_line(32'h1000, 0, 0, -1, 0);
        pulse(1'b0);
        exp_lb_bank = 1'b0;
        fetch_line(32'h1100, 0, 1, 2, 1);
        check("underrun_set", 32'(underrun), 1);
        check("rd_bank_no_swap", 32'(rd_bank), 1);
        check("lb_bank_no_swap", 32'(lb_bank), 0);
        check("line_idx_underrun", 32'(line_idx), 2);
        pulse(1'b0);
        check("rd_bank_swap_after_underrun", 32'(rd_bank), 0);
        check("lb_bank_swap_after_underrun", 32'(lb_bank), 1);
        exp_lb_bank = 1'b1;
        fetch_line(32'h1200, 0, 0, -1, 0);
        check("underrun_sticky", 32'(underrun), 1);

        // Frame request during an active fetch is deferred until that line is done
        pulse(1'b0);
        pulse(1'b1);
        frame_base = 32'h2000;
        exp_lb_bank = 1'b0;
        fetch_line(32'h1000, 0, 0, 2, 2);
        fetch_line(32'h2000, 0, 0, -1, 0);
        check("line_idx_after_deferred_frame", 32'(line_idx), 1);
        check("rd_bank_deferred_frame", 32'(rd_bank), 1);
        check("lb_bank_deferred_frame", 32'(lb_bank), 0);

        // Reset in the middle of a burst, then stray read data
        pulse(1'b0);
        exp_lb_bank = 1'b1;
        wait_rd_req();
        check("rd_addr_line1_new_frame", rd_addr, 32'h2100);
        rd_ack = 1'b1;
        @(negedge pclk);
        rd_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_valid = 1'b1;
            rd_data  = pat(32'h2100, i);
            exp_wr.push_back('{waddr: 32'(i), data: pat(32'h2100, i), bank: 1'b1});
            @(negedge pclk);
        end
        rd_valid = 1'b0;
        @(negedge pclk);
        reset = 1'b1;
        @(negedge pclk);
        check_reset_outputs();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_valid = (i < 4);
            rd_data  = 32'hDEAD0000 + 32'(i);
            @(negedge pclk);
            check("no_lb_we_after_reset", 32'(lb_we), 0);
            check("no_rd_req_after_reset", 32'(rd_req), 0);
        end
        rd_valid = 1'b0;
        check("scoreboard_final", 32'(exp_wr.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
